// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and types for the HUB75 capture path.
//   HUB75_NUM_COLS / HUB75_SCAN_RATE / HUB75_ADDR_W : default panel geometry
//   rgb_t       : one {r,g,b} pixel
//   hub75_row_t : captured row record at the default geometry
//   next_plane(): bit-plane sequencing rule for repeated row addresses
package hub75_pkg;

   localparam int HUB75_NUM_COLS  = 64;
   localparam int HUB75_SCAN_RATE = 32;
   localparam int HUB75_ADDR_W    = $clog2(HUB75_SCAN_RATE);
   localparam int HUB75_LEN_W     = $clog2(HUB75_NUM_COLS) + 1;
   localparam int HUB75_OE_CNT_W  = 16;

   typedef logic [2:0] rgb_t;

   typedef struct packed {
      logic [HUB75_ADDR_W-1:0]         addr;
      logic [3:0]                      plane;
      rgb_t [HUB75_NUM_COLS-1:0]       rgb0;
      rgb_t [HUB75_NUM_COLS-1:0]       rgb1;
      logic [HUB75_LEN_W-1:0]          len;
      logic                            err;
      logic [HUB75_OE_CNT_W-1:0]       oe_time;
   } hub75_row_t;

   // Same address latched again means the driver is walking the bit-planes
   // of that row; anything else restarts at plane 0. Wraps mod 16.
   function automatic logic [3:0] next_plane(input logic same_row, input logic [3:0] plane);
      return same_row ? plane + 4'd1 : 4'd0;
   endfunction

endpackage

// File: rtl/hub75_input_sync.sv
// hub75_input_sync: synchronizes every HUB75 pin into clk_in and flags rising
// edges of the shift clock and latch.
//   clk_in, rst_n_in      : system clock, async active-low reset
//   hub75_*_in            : raw panel pins
//   clk_rise_o/latch_rise_o : one-cycle pulses, registered
//   oe_n_o, addr_o, rgb*_o  : synced levels, time-aligned with the rise pulses
module hub75_input_sync
   import hub75_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = HUB75_ADDR_W
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              hub75_clk_in,
   input  logic              hub75_latch_in,
   input  logic              hub75_oe_in,
   input  logic [ADDR_W-1:0] hub75_addr_in,
   input  rgb_t              hub75_rgb0_in,
   input  rgb_t              hub75_rgb1_in,
   output logic              clk_rise_o,
   output logic              latch_rise_o,
   output logic              oe_n_o,
   output logic [ADDR_W-1:0] addr_o,
   output rgb_t              rgb0_o,
   output rgb_t              rgb1_o
);

   localparam int W     = ADDR_W + 9;
   localparam int B_CLK = W - 1;
   localparam int B_LAT = W - 2;
   localparam int B_OE  = W - 3;
   // OE resets to its inactive (high) level so the on-time counter does not
   // count phantom cycles while the chain fills after reset.
   localparam logic [W-1:0] RST_VAL = W'(1) << B_OE;

   logic [SYNC_STAGES-1:0][W-1:0] sync_q;
   logic [W-1:0]                  pins;
   logic [W-1:0]                  s;
   logic [W-1:0]                  lvl_q;
   logic                          clk_rise_q;
   logic                          latch_rise_q;

   assign pins = {hub75_clk_in, hub75_latch_in, hub75_oe_in, hub75_addr_in,
                  hub75_rgb0_in, hub75_rgb1_in};
   assign s    = sync_q[SYNC_STAGES-1];

   // lvl_q is both the edge-detect reference and the data stage that lines
   // up with the registered rise pulses.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q       <= {SYNC_STAGES{RST_VAL}};
         lvl_q        <= RST_VAL;
         clk_rise_q   <= 1'b0;
         latch_rise_q <= 1'b0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         lvl_q        <= s;
         clk_rise_q   <= s[B_CLK] & ~lvl_q[B_CLK];
         latch_rise_q <= s[B_LAT] & ~lvl_q[B_LAT];
      end
   end

   assign clk_rise_o   = clk_rise_q;
   assign latch_rise_o = latch_rise_q;
   assign oe_n_o       = lvl_q[B_OE];
   assign addr_o       = lvl_q[B_OE-1 -: ADDR_W];
   assign rgb0_o       = lvl_q[5:3];
   assign rgb1_o       = lvl_q[2:0];

endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: rebuilds each latched HUB75 row into one record on a
// valid/ready stream (loopback self-test of the panel driver).
//   clk_in, rst_n_in   : system clock (>= 4x HUB75 clock), async active-low reset
//   hub75_*_in         : panel bus pins (OE active-low)
//   row_valid_out / row_ready_in : record handshake
//   row_addr/plane/rgb0/rgb1/len/err_out : record fields
//   overflow_out       : sticky, a row arrived while the previous one was unaccepted
//   oe_time_out        : OE on-time before latch; only built when
//                        HUB75_CAPTURE_OE_TIME_EN is defined, otherwise tied 0
module hub75_capture
   import hub75_pkg::*;
#(
   parameter  int NUM_COLS    = HUB75_NUM_COLS,
   parameter  int SCAN_RATE   = HUB75_SCAN_RATE,
   parameter  int SYNC_STAGES = 2,
   parameter  int OE_CNT_W    = HUB75_OE_CNT_W,
   localparam int ADDR_W      = $clog2(SCAN_RATE),
   localparam int LEN_W       = $clog2(NUM_COLS) + 1
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      hub75_clk_in,
   input  logic                      hub75_latch_in,
   input  logic                      hub75_oe_in,
   input  logic [ADDR_W-1:0]         hub75_addr_in,
   input  logic [2:0]                hub75_rgb0_in,
   input  logic [2:0]                hub75_rgb1_in,
   output logic                      row_valid_out,
   input  logic                      row_ready_in,
   output logic [ADDR_W-1:0]         row_addr_out,
   output logic [3:0]                row_plane_out,
   output logic [NUM_COLS-1:0][2:0]  row_rgb0_out,
   output logic [NUM_COLS-1:0][2:0]  row_rgb1_out,
   output logic [LEN_W-1:0]          row_len_out,
   output logic                      row_err_out,
   output logic                      overflow_out,
   output logic [OE_CNT_W-1:0]       oe_time_out
);

   typedef struct packed {
      logic [ADDR_W-1:0]     addr;
      logic [3:0]            plane;
      rgb_t [NUM_COLS-1:0]   rgb0;
      rgb_t [NUM_COLS-1:0]   rgb1;
      logic [LEN_W-1:0]      len;
      logic                  err;
      logic [OE_CNT_W-1:0]   oe_time;
   } row_t;

   logic              clk_rise, latch_rise, oe_n_s;
   logic [ADDR_W-1:0] addr_s;
   rgb_t              rgb0_s, rgb1_s;

   hub75_input_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .ADDR_W      (ADDR_W)
   ) u_sync (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .hub75_clk_in   (hub75_clk_in),
      .hub75_latch_in (hub75_latch_in),
      .hub75_oe_in    (hub75_oe_in),
      .hub75_addr_in  (hub75_addr_in),
      .hub75_rgb0_in  (hub75_rgb0_in),
      .hub75_rgb1_in  (hub75_rgb1_in),
      .clk_rise_o     (clk_rise),
      .latch_rise_o   (latch_rise),
      .oe_n_o         (oe_n_s),
      .addr_o         (addr_s),
      .rgb0_o         (rgb0_s),
      .rgb1_o         (rgb1_s)
   );

   rgb_t [NUM_COLS-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic [LEN_W-1:0]    len_q, len_d, len_shift;
   logic [3:0]          plane_q, plane_d, row_plane;
   logic [ADDR_W-1:0]   prev_addr_q, prev_addr_d;
   logic                prev_vld_q, prev_vld_d;
   row_t                rec_q, rec_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic [OE_CNT_W-1:0] oe_snap;

`ifdef HUB75_CAPTURE_OE_TIME_EN
   logic [OE_CNT_W-1:0] oe_cnt_q, oe_cnt_d;

   always_comb begin
      oe_cnt_d = oe_cnt_q;
      if (latch_rise)                      oe_cnt_d = '0;
      else if (!oe_n_s && oe_cnt_q != '1)  oe_cnt_d = oe_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) oe_cnt_q <= '0;
      else           oe_cnt_q <= oe_cnt_d;
   end

   assign oe_snap = oe_cnt_q;
`else
   logic unused_oe;
   assign unused_oe = oe_n_s;
   assign oe_snap   = '0;
`endif

   always_comb begin
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      len_shift   = len_q;
      plane_d     = plane_q;
      prev_addr_d = prev_addr_q;
      prev_vld_d  = prev_vld_q;
      rec_d       = rec_q;
      ovf_d       = ovf_q;
      valid_d     = valid_q;
      row_plane   = next_plane(prev_vld_q && (addr_s == prev_addr_q), plane_q);

      // Shift happens before the latch is evaluated so a same-cycle
      // clock edge still contributes its pixel to the record.
      if (clk_rise) begin
         buf0_d = {buf0_q[NUM_COLS-2:0], rgb0_s};
         buf1_d = {buf1_q[NUM_COLS-2:0], rgb1_s};
         if (len_q != '1) len_shift = len_q + 1'b1;
      end
      len_d = len_shift;

      if (valid_q && row_ready_in) valid_d = 1'b0;

      if (latch_rise) begin
         len_d       = '0;
         plane_d     = row_plane;
         prev_addr_d = addr_s;
         prev_vld_d  = 1'b1;
         if (!valid_q || row_ready_in) begin
            rec_d.addr    = addr_s;
            rec_d.plane   = row_plane;
            rec_d.rgb0    = buf0_d;
            rec_d.rgb1    = buf1_d;
            rec_d.len     = len_shift;
            rec_d.err     = (len_shift != LEN_W'(NUM_COLS));
            rec_d.oe_time = oe_snap;
            valid_d       = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         buf0_q      <= '0;
         buf1_q      <= '0;
         len_q       <= '0;
         plane_q     <= '0;
         prev_addr_q <= '0;
         prev_vld_q  <= 1'b0;
         rec_q       <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         len_q       <= len_d;
         plane_q     <= plane_d;
         prev_addr_q <= prev_addr_d;
         prev_vld_q  <= prev_vld_d;
         rec_q       <= rec_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign row_valid_out = valid_q;
   assign row_addr_out  = rec_q.addr;
   assign row_plane_out = rec_q.plane;
   assign row_rgb0_out  = rec_q.rgb0;
   assign row_rgb1_out  = rec_q.rgb1;
   assign row_len_out   = rec_q.len;
   assign row_err_out   = rec_q.err;
   assign oe_time_out   = rec_q.oe_time;
   assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: directed bench for hub75_capture with a record scoreboard.
module tb_hub75_capture;

   localparam int N  = 64;
   localparam int AW = 5;
   localparam int LW = 7;
   localparam int OW = 16;
`ifdef HUB75_CAPTURE_OE_TIME_EN
   localparam bit OE_EN = 1'b1;
`else
   localparam bit OE_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b1;
   logic hclk = 1'b0, hlat = 1'b0, hoe = 1'b1, ready = 1'b1;
   logic [AW-1:0] haddr = '0;
   logic [2:0] h0 = '0, h1 = '0;

   logic              row_valid, row_err, overflow;
   logic [AW-1:0]     row_addr;
   logic [3:0]        row_plane;
   logic [N-1:0][2:0] row_rgb0, row_rgb1;
   logic [LW-1:0]     row_len;
   logic [OW-1:0]     oe_time;

   hub75_capture dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .hub75_clk_in   (hclk),
      .hub75_latch_in (hlat),
      .hub75_oe_in    (hoe),
      .hub75_addr_in  (haddr),
      .hub75_rgb0_in  (h0),
      .hub75_rgb1_in  (h1),
      .row_valid_out  (row_valid),
      .row_ready_in   (ready),
      .row_addr_out   (row_addr),
      .row_plane_out  (row_plane),
      .row_rgb0_out   (row_rgb0),
      .row_rgb1_out   (row_rgb1),
      .row_len_out    (row_len),
      .row_err_out    (row_err),
      .overflow_out   (overflow),
      .oe_time_out    (oe_time)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0]     addr;
      logic [3:0]        plane;
      logic [N-1:0][2:0] rgb0;
      logic [N-1:0][2:0] rgb1;
      logic [LW-1:0]     len;
      logic              err;
      logic [OW-1:0]     oe;
   } exp_t;

   exp_t       sb[$];
   exp_t       held;
   logic [2:0] hist0[$], hist1[$];
   int         pix_cnt  = 0;
   int         last_lat = 0;
   int         n_cmp    = 0;
   int         n_bad    = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Shift n pixels; pixel i = (i+seed)[2:0] upper, its inverse lower.
   task automatic send_row(input int n, input logic [AW-1:0] addr, input int seed);
      haddr = addr;
      for (int i = 0; i < n; i++) begin
         h0 = 3'(i + seed);
         h1 = ~3'(i + seed);
         hist0.push_back(h0);
         hist1.push_back(h1);
         if (hist0.size() > N) begin
            void'(hist0.pop_front());
            void'(hist1.pop_front());
         end
         pix_cnt++;
         tick(2);
         hclk = 1'b1;
         tick(3);
         hclk = 1'b0;
         tick(2);
      end
   endtask

   task automatic check_record(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, ".unexpected"}, 256'(1), 256'(0));
         return;
      end
      e    = sb.pop_front();
      held = e;
      chk({tag, ".addr"},  256'(row_addr),  256'(e.addr));
      chk({tag, ".plane"}, 256'(row_plane), 256'(e.plane));
      chk({tag, ".len"},   256'(row_len),   256'(e.len));
      chk({tag, ".err"},   256'(row_err),   256'(e.err));
      chk({tag, ".rgb0"},  256'(row_rgb0),  256'(e.rgb0));
      chk({tag, ".rgb1"},  256'(row_rgb1),  256'(e.rgb1));
      chk({tag, ".oe"},    256'(oe_time),   256'(e.oe));
   endtask

   // Raise latch; if accept, the expected record is queued and the first
   // valid seen within the window is checked against it.
   task automatic latch_row(input string tag, input logic [3:0] plane, input bit accept,
                            input int oe_cyc);
      exp_t e;
      int   l;
      bit   got;
      e.addr  = haddr;
      e.plane = plane;
      for (int k = 0; k < N; k++) begin
         e.rgb0[k] = (k < hist0.size()) ? hist0[hist0.size()-1-k] : 3'd0;
         e.rgb1[k] = (k < hist1.size()) ? hist1[hist1.size()-1-k] : 3'd0;
      end
      l       = (pix_cnt > 127) ? 127 : pix_cnt;
      e.len   = LW'(l);
      e.err   = (l != N);
      e.oe    = OE_EN ? OW'(oe_cyc) : '0;
      pix_cnt = 0;
      if (accept) sb.push_back(e);
      got  = 1'b0;
      hlat = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick(1);
         if (c == 3) hlat = 1'b0;
         if (accept && !got && row_valid) begin
            got      = 1'b1;
            last_lat = c;
            check_record(tag);
         end
      end
      if (accept) chk({tag, ".timeout"}, 256'(got), 256'(1));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(3);
      chk("rst.valid", 256'(row_valid), 256'(0));
      chk("rst.ovf",   256'(overflow),  256'(0));
      chk("rst.len",   256'(row_len),   256'(0));
      chk("rst.oe",    256'(oe_time),   256'(0));
      rst_n = 1'b1;
      tick(3);

      // 1: full row, latency and pixel ordering
      send_row(64, 5, 0);
      tick(2);
      latch_row("t1", 4'd0, 1'b1, 0);
      chk("t1.latency", 256'(last_lat), 256'(4));
      chk("t1.px63",    256'(row_rgb0[63]), 256'(3'd0));
      chk("t1.px0",     256'(row_rgb0[0]),  256'(3'd7));

      // 3: short and long rows
      send_row(60, 7, 3);
      tick(2);
      latch_row("t3a", 4'd0, 1'b1, 0);
      send_row(70, 7, 5);
      tick(2);
      latch_row("t3b", 4'd1, 1'b1, 0);
      chk("t3b.px63", 256'(row_rgb0[63]), 256'(3'd3));
      chk("t3b.px0",  256'(row_rgb0[0]),  256'(3'd2));

      // 2: bit-plane sequencing
      send_row(64, 5, 1); tick(2); latch_row("t2a", 4'd0, 1'b1, 0);
      send_row(64, 5, 2); tick(2); latch_row("t2b", 4'd1, 1'b1, 0);
      send_row(64, 5, 3); tick(2); latch_row("t2c", 4'd2, 1'b1, 0);
      send_row(64, 6, 4); tick(2); latch_row("t2d", 4'd0, 1'b1, 0);

      // 4: back-pressure, drop and overflow
      ready = 1'b0;
      send_row(64, 5, 2); tick(2); latch_row("t4a", 4'd0, 1'b1, 0);
      send_row(64, 5, 4); tick(2);
      chk("t4.held_valid", 256'(row_valid), 256'(1));
      latch_row("t4b", 4'd1, 1'b0, 0);
      chk("t4.ovf",   256'(overflow),  256'(1));
      chk("t4.valid", 256'(row_valid), 256'(1));
      chk("t4.rgb0",  256'(row_rgb0),  256'(held.rgb0));
      chk("t4.plane", 256'(row_plane), 256'(held.plane));
      ready = 1'b1;
      tick(1);
      chk("t4.drain", 256'(row_valid), 256'(0));
      tick(2);
      chk("t4.after", 256'(row_valid), 256'(0));
      chk("t4.sb",    256'(sb.size()), 256'(0));

      // 5: reset mid-row
      send_row(30, 5, 0);
      rst_n = 1'b0;
      #1;
      chk("t5.valid", 256'(row_valid), 256'(0));
      chk("t5.ovf",   256'(overflow),  256'(0));
      chk("t5.len",   256'(row_len),   256'(0));
      chk("t5.rgb0",  256'(row_rgb0),  256'(0));
      hist0.delete();
      hist1.delete();
      pix_cnt = 0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      send_row(64, 5, 6); tick(2); latch_row("t5", 4'd0, 1'b1, 0);

      // 6: OE on-time
      send_row(64, 3, 7);
      hoe = 1'b0;
      tick(100);
      hoe = 1'b1;
      tick(2);
      latch_row("t6", 4'd0, 1'b1, 100);
      chk("t6.sb", 256'(sb.size()), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
